// File: rtl/spawn_validity_arbiter.sv
// Spawn validity arbiter: steps three spawn generators in turn and serialises their tile checks
// against the maze, pacman and an 8-entry occupancy table. Macro: SPAWN_PM_EXCLUSION_EN (3x3 pacman keep-out).
module spawn_validity_arbiter #(
    parameter int unsigned MAZE_W = 40,
    parameter int unsigned MAZE_H = 30
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            level_start,
    input  logic [2:0]      gen_done,
    input  logic [2:0]      chk_req,
    input  logic [2:0][6:0] chk_x,
    input  logic [2:0][6:0] chk_y,
    input  logic [6:0]      pm_tile_x,
    input  logic [6:0]      pm_tile_y,
    output logic [6:0]      maze_rd_x,
    output logic [6:0]      maze_rd_y,
    input  logic            maze_is_wall,
    output logic [2:0]      should_generate,
    output logic [2:0]      chk_ack,
    output logic [2:0]      chk_valid,
    output logic            all_spawned,
    output logic            busy,
    output logic            occ_overflow
);
    localparam int unsigned CW     = 7;
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned OCC_N  = 8;
    localparam int unsigned OCC_IW = 3;

    typedef enum logic [2:0] {SEQ_IDLE, SEQ_GEN0, SEQ_GEN1, SEQ_GEN2, SEQ_DONE} seq_e;
    typedef enum logic [1:0] {CHK_IDLE, CHK_LOOKUP, CHK_EVAL} chk_e;

    seq_e                     seq_q, seq_d;
    chk_e                     chk_q, chk_d;
    logic [1:0]               gnt_q, gnt_d, last_q, last_d;
    logic [CW-1:0]            x_q, x_d, y_q, y_d;
    logic [OCC_N-1:0]         occ_v_q, occ_v_d;
    logic [OCC_N-1:0][CW-1:0] occ_x_q, occ_x_d, occ_y_q, occ_y_d;
    logic                     ovf_q, ovf_d;

    logic [3:0]               req_ext;
    logic [3:0][CW-1:0]       req_x, req_y;
    logic                     gnt_found;
    logic [1:0]               gnt_idx, cand;
    logic                     in_range, pm_hit, occ_hit, tile_ok, ack_c, valid_c;
    logic                     free_found;
    logic [OCC_IW-1:0]        free_idx;

    // Pad to four requesters so a 2-bit index never selects out of range
    assign req_ext = {1'b0, chk_req};
    assign req_x   = {{CW{1'b0}}, chk_x};
    assign req_y   = {{CW{1'b0}}, chk_y};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            seq_q   <= SEQ_IDLE;
            chk_q   <= CHK_IDLE;
            gnt_q   <= 2'd0;
            last_q  <= 2'd2;
            x_q     <= '0;
            y_q     <= '0;
            occ_v_q <= '0;
            occ_x_q <= '0;
            occ_y_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            chk_q   <= chk_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
            occ_v_q <= occ_v_d;
            occ_x_q <= occ_x_d;
            occ_y_q <= occ_y_d;
            ovf_q   <= ovf_d;
        end
    end

    // Level sequencer: one generator enabled at a time
    always_comb begin
        seq_d           = seq_q;
        should_generate = 3'b000;
        all_spawned     = 1'b0;
        if (level_start) begin
            seq_d = SEQ_GEN0;
        end else begin
            case (seq_q)
                SEQ_GEN0: if (gen_done[0]) seq_d = SEQ_GEN1;
                SEQ_GEN1: if (gen_done[1]) seq_d = SEQ_GEN2;
                SEQ_GEN2: if (gen_done[2]) seq_d = SEQ_DONE;
                default:  ;
            endcase
        end
        case (seq_q)
            SEQ_GEN0: should_generate = 3'b001;
            SEQ_GEN1: should_generate = 3'b010;
            SEQ_GEN2: should_generate = 3'b100;
            SEQ_DONE: all_spawned     = 1'b1;
            default:  ;
        endcase
    end

    // Round-robin search starting one past the last grant
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        cand      = last_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!gnt_found && req_ext[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        in_range = (32'(x_q) < MAZE_W) && (32'(y_q) < MAZE_H);
`ifdef SPAWN_PM_EXCLUSION_EN
        pm_hit = ({1'b0, x_q} + 8'd1 >= {1'b0, pm_tile_x}) && ({1'b0, x_q} <= {1'b0, pm_tile_x} + 8'd1) &&
                 ({1'b0, y_q} + 8'd1 >= {1'b0, pm_tile_y}) && ({1'b0, y_q} <= {1'b0, pm_tile_y} + 8'd1);
`else
        pm_hit = (x_q == pm_tile_x) && (y_q == pm_tile_y);
`endif
        occ_hit    = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < OCC_N; i++) begin
            if (occ_v_q[i] && (occ_x_q[i] == x_q) && (occ_y_q[i] == y_q)) occ_hit = 1'b1;
            if (!free_found && !occ_v_q[i]) begin
                free_found = 1'b1;
                free_idx   = OCC_IW'(i);
            end
        end
        tile_ok = in_range && !maze_is_wall && !pm_hit && !occ_hit;
    end

    // Check FSM; ack is combinational in EVAL so that a same-cycle level_start can suppress it
    always_comb begin
        chk_d   = chk_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        ack_c   = 1'b0;
        valid_c = 1'b0;
        case (chk_q)
            CHK_IDLE: begin
                if (gnt_found) begin
                    chk_d  = CHK_LOOKUP;
                    gnt_d  = gnt_idx;
                    last_d = gnt_idx;
                    x_d    = req_x[gnt_idx];
                    y_d    = req_y[gnt_idx];
                end
            end
            CHK_LOOKUP: chk_d = level_start ? CHK_IDLE : CHK_EVAL;
            CHK_EVAL: begin
                chk_d   = CHK_IDLE;
                ack_c   = !level_start;
                valid_c = !level_start && tile_ok;
            end
            default: chk_d = CHK_IDLE;
        endcase
    end

    // Occupancy table: record valid tiles in the lowest free slot, flag overflow when full
    always_comb begin
        occ_v_d = occ_v_q;
        occ_x_d = occ_x_q;
        occ_y_d = occ_y_q;
        ovf_d   = ovf_q;
        if (level_start) begin
            occ_v_d = '0;
            ovf_d   = 1'b0;
        end else if (valid_c) begin
            if (free_found) begin
                occ_v_d[free_idx] = 1'b1;
                occ_x_d[free_idx] = x_q;
                occ_y_d[free_idx] = y_q;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign chk_ack      = ack_c   ? (3'b001 << gnt_q) : 3'b000;
    assign chk_valid    = valid_c ? (3'b001 << gnt_q) : 3'b000;
    assign maze_rd_x    = x_q;
    assign maze_rd_y    = y_q;
    assign occ_overflow = ovf_q;
    assign busy         = (chk_q != CHK_IDLE) || (should_generate != 3'b000);

endmodule

// File: tb/tb_spawn_validity_arbiter.sv
// Randomised scoreboard bench for spawn_validity_arbiter; honours SPAWN_PM_EXCLUSION_EN like the DUT.
module tb_spawn_validity_arbiter;
    localparam int unsigned MAZE_W = 40;
    localparam int unsigned MAZE_H = 30;

    logic            clk = 1'b0;
    logic            resetN, level_start, maze_is_wall;
    logic [2:0]      gen_done, chk_req, should_generate, chk_ack, chk_valid;
    logic [2:0][6:0] chk_x, chk_y;
    logic [6:0]      pm_tile_x, pm_tile_y, maze_rd_x, maze_rd_y;
    logic            all_spawned, busy, occ_overflow;

    spawn_validity_arbiter #(.MAZE_W(MAZE_W), .MAZE_H(MAZE_H)) dut (
        .clk(clk), .resetN(resetN), .level_start(level_start), .gen_done(gen_done),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .pm_tile_x(pm_tile_x), .pm_tile_y(pm_tile_y),
        .maze_rd_x(maze_rd_x), .maze_rd_y(maze_rd_y), .maze_is_wall(maze_is_wall),
        .should_generate(should_generate), .chk_ack(chk_ack), .chk_valid(chk_valid),
        .all_spawned(all_spawned), .busy(busy), .occ_overflow(occ_overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; bit valid; int cyc; } exp_t;
    exp_t sb[$];
    exp_t e;
    int   occ_x[$], occ_y[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, rr_last = 2, seq_phase = -1;
    bit   exp_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_wall(input int x, input int y);
        return ((x * 3 + y * 5) % 7) == 0;
    endfunction

    // Synchronous maze ROM: data one cycle after address
    always @(posedge clk) maze_is_wall <= is_wall(int'(maze_rd_x), int'(maze_rd_y));

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic bit pm_reject(input int x, input int y);
        int dx, dy;
        dx = x - int'(pm_tile_x);
        dy = y - int'(pm_tile_y);
`ifdef SPAWN_PM_EXCLUSION_EN
        return (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1);
`else
        return (dx == 0) && (dy == 0);
`endif
    endfunction

    // Reference rule: decide validity, then record it in the 8-slot table
    function automatic bit model_check(input int x, input int y);
        bit ok;
        ok = (x < int'(MAZE_W)) && (y < int'(MAZE_H)) && !is_wall(x, y) && !pm_reject(x, y);
        foreach (occ_x[i]) if (occ_x[i] == x && occ_y[i] == y) ok = 1'b0;
        if (ok) begin
            if (occ_x.size() < 8) begin
                occ_x.push_back(x);
                occ_y.push_back(y);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic void model_clear();
        occ_x.delete();
        occ_y.delete();
        exp_ovf   = 1'b0;
        seq_phase = 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ls;
        level_start = 1'b1;
        tick;
        level_start = 1'b0;
        model_clear();
    endtask

    task automatic pick(output int x, output int y);
        int k;
        if (occ_x.size() != 0 && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, occ_x.size() - 1);
            x = occ_x[k];
            y = occ_y[k];
        end else begin
            x = $urandom_range(0, 44);
            y = $urandom_range(0, 33);
        end
    endtask

    task automatic single_check(input int r, input int x, input int y);
        bit v;
        v = model_check(x, y);
        sb.push_back('{r, v, cyc + 2});
        chk_x[r] = 7'(x);
        chk_y[r] = 7'(y);
        chk_req[r] = 1'b1;
        tick;
        check("busy_in_check", int'(busy), 1);
        tick;
        chk_req[r] = 1'b0;
        tick;
        rr_last = r;
        check("busy_after_check", int'(busy), (seq_phase >= 0 && seq_phase <= 2) ? 1 : 0);
        check("occ_overflow", int'(occ_overflow), int'(exp_ovf));
    endtask

    task automatic multi_check(input logic [2:0] mask);
        int order[$];
        int n0, r, x, y;
        bit v;
        n0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            r = (rr_last + k) % 3;
            if (mask[r]) order.push_back(r);
        end
        foreach (order[p]) begin
            r = order[p];
            pick(x, y);
            chk_x[r] = 7'(x);
            chk_y[r] = 7'(y);
            v = model_check(x, y);
            sb.push_back('{r, v, n0 + 2 + 3 * p});
        end
        chk_req = mask;
        foreach (order[p]) begin
            while (cyc != n0 + 2 + 3 * p) tick;
            chk_req[order[p]] = 1'b0;
        end
        tick;
        rr_last = order[order.size() - 1];
        check("occ_overflow", int'(occ_overflow), int'(exp_ovf));
    endtask

    // Monitor: every presented ack is matched against the oldest expectation
    always @(negedge clk) begin
        if (chk_ack != 3'b000) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack=%b, expected none (cycle %0d)", chk_ack, cyc);
            end else begin
                e = sb.pop_front();
                check("ack_idx", int'(chk_ack), 1 << e.idx);
                check("ack_valid", int'(chk_valid), e.valid ? (1 << e.idx) : 0);
                check("ack_cycle", cyc, e.cyc);
            end
        end else begin
            check("valid_without_ack", int'(chk_valid), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, x, y, cnt, op;
        resetN = 1'b0; level_start = 1'b0; gen_done = '0; chk_req = '0;
        chk_x = '0; chk_y = '0; pm_tile_x = 7'd20; pm_tile_y = 7'd20;
        #12;
        check("rst_should_generate", int'(should_generate), 0);
        check("rst_all_spawned", int'(all_spawned), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_occ_overflow", int'(occ_overflow), 0);
        check("rst_maze_rd_x", int'(maze_rd_x), 0);
        resetN = 1'b1;
        tick;

        // Sequencer walk
        check("seq_idle_sg", int'(should_generate), 0);
        pulse_ls;
        check("seq_gen0_sg", int'(should_generate), 1);
        check("seq_gen0_busy", int'(busy), 1);
        gen_done = 3'b110; tick;
        check("seq_other_done_ignored", int'(should_generate), 1);
        gen_done = 3'b001; tick; gen_done = '0;
        check("seq_gen1_sg", int'(should_generate), 2);
        gen_done = 3'b010; tick; gen_done = '0;
        check("seq_gen2_sg", int'(should_generate), 4);
        check("seq_gen2_spawned", int'(all_spawned), 0);
        gen_done = 3'b100; tick; gen_done = '0;
        seq_phase = 3;
        check("seq_done_sg", int'(should_generate), 0);
        check("seq_done_spawned", int'(all_spawned), 1);
        check("seq_done_busy", int'(busy), 0);

        // Basic check, duplicate tile, range / wall / pacman rules
        single_check(0, 5, 3);
        single_check(1, 5, 3);
        single_check(0, 40, 3);
        single_check(1, 7, 0);
        single_check(2, 39, 29);
        single_check(0, 39, 30);
        pm_tile_x = 7'd10; pm_tile_y = 7'd10;
        single_check(1, 11, 9);
        single_check(2, 10, 10);
        pm_tile_x = 7'd20; pm_tile_y = 7'd20;

        // Fill the table past capacity
        pulse_ls;
        check("ls_from_done_sg", int'(should_generate), 1);
        cnt = 0;
        for (int xi = 30; cnt < 9; xi++) begin
            if (!is_wall(xi, 5)) begin
                single_check(cnt % 3, xi, 5);
                cnt++;
            end
        end
        check("ovf_after_ninth", int'(occ_overflow), 1);
        single_check(1, 39, 5);
        pulse_ls;
        check("ovf_cleared", int'(occ_overflow), 0);
        single_check(2, 30, 5);
        single_check(2, 4, 4);

        // Reset in the middle of a check
        chk_x[0] = 7'd5; chk_y[0] = 7'd6; chk_req = 3'b001;
        tick;
        check("lookup_addr_x", int'(maze_rd_x), 5);
        resetN = 1'b0;
        #1;
        check("midrst_should_generate", int'(should_generate), 0);
        check("midrst_ack", int'(chk_ack), 0);
        check("midrst_valid", int'(chk_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_maze_rd_x", int'(maze_rd_x), 0);
        check("midrst_maze_rd_y", int'(maze_rd_y), 0);
        chk_req = '0;
        tick; tick;
        resetN = 1'b1;
        occ_x.delete(); occ_y.delete(); exp_ovf = 1'b0; rr_last = 2; seq_phase = -1;
        tick;

        // All three held: order 0,1,2,0 with an ack every 3 cycles
        n0 = cyc;
        chk_x[0] = 7'd1; chk_y[0] = 7'd1;
        chk_x[1] = 7'd2; chk_y[1] = 7'd1;
        chk_x[2] = 7'd4; chk_y[2] = 7'd1;
        sb.push_back('{0, model_check(1, 1), n0 + 2});
        sb.push_back('{1, model_check(2, 1), n0 + 5});
        sb.push_back('{2, model_check(4, 1), n0 + 8});
        sb.push_back('{0, model_check(1, 1), n0 + 11});
        chk_req = 3'b111;
        while (cyc != n0 + 5) tick;
        chk_req[1] = 1'b0;
        while (cyc != n0 + 8) tick;
        chk_req[2] = 1'b0;
        while (cyc != n0 + 11) tick;
        chk_req[0] = 1'b0;
        tick;
        rr_last = 0;
        single_check(1, 4, 4);

        // level_start during LOOKUP aborts, requester is re-granted
        n0 = cyc;
        chk_x[0] = 7'd2; chk_y[0] = 7'd2; chk_req = 3'b001;
        tick;
        level_start = 1'b1;
        tick;
        level_start = 1'b0;
        model_clear();
        sb.push_back('{0, model_check(2, 2), n0 + 4});
        while (cyc != n0 + 4) tick;
        chk_req = '0;
        tick;
        rr_last = 0;

        // level_start during EVAL aborts as well
        n0 = cyc;
        chk_x[2] = 7'd6; chk_y[2] = 7'd2; chk_req = 3'b100;
        tick; tick;
        level_start = 1'b1;
        tick;
        level_start = 1'b0;
        model_clear();
        sb.push_back('{2, model_check(6, 2), n0 + 5});
        while (cyc != n0 + 5) tick;
        chk_req = '0;
        tick;
        rr_last = 2;
        check("abort_ovf", int'(occ_overflow), 0);

        // Randomised traffic
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                pm_tile_x = 7'($urandom_range(0, 44));
                pm_tile_y = 7'($urandom_range(0, 33));
            end
            if (op == 0) begin
                pulse_ls;
                check("rand_ls_ovf", int'(occ_overflow), 0);
            end else if (op <= 3) begin
                multi_check(3'($urandom_range(1, 7)));
            end else begin
                pick(x, y);
                single_check($urandom_range(0, 2), x, y);
            end
        end

        repeat (3) tick;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spawn_validity_arbiter.md
SPAWN_VALIDITY_ARBITER -- requirements
Module: spawn_validity_arbiter

Interface
REQ-001 The block SHALL have parameter MAZE_W, default 40, giving the maze width in tiles; any x >= MAZE_W is out of range.
REQ-002 The block SHALL have parameter MAZE_H, default 30, giving the maze height in tiles; any y >= MAZE_H is out of range.
REQ-003 clk  in  1  system clock; the only clock, all state on its rising edge.
REQ-004 resetN  in  1  asynchronous, active-low reset.
REQ-005 level_start  in  1  one-cycle pulse that starts the spawn sequence for a new level.
REQ-006 gen_done  in  [2:0]  requester i has finished all of its placements.
REQ-007 chk_req  in  [2:0]  requester i asks for a tile check; it is held high until chk_ack[i].
REQ-008 chk_x, chk_y  in  [2:0][6:0]  tile coordinates for each requester's check.
REQ-009 pm_tile_x, pm_tile_y  in  7 each  current pacman tile.
REQ-010 maze_rd_x, maze_rd_y  out  7 each  maze lookup address.
REQ-011 maze_is_wall  in  1  maze lookup data, valid exactly one cycle after the address.
REQ-012 should_generate  out  [2:0]  one-hot; enables requester i to generate.
REQ-013 chk_ack  out  [2:0]  one-cycle pulse; the check result is available.
REQ-014 chk_valid  out  [2:0]  check result, qualified by chk_ack.
REQ-015 all_spawned, busy, occ_overflow  out  1 each  status outputs.

Function
REQ-016 The sequencer FSM SHALL use states SEQ_IDLE, SEQ_GEN0, SEQ_GEN1, SEQ_GEN2 and SEQ_DONE.
REQ-017 In SEQ_GENk, should_generate SHALL equal one-hot k; in every other state it SHALL be 0.
REQ-018 When gen_done[k] is high in SEQ_GENk, the sequencer SHALL advance to SEQ_GEN(k+1), or to SEQ_DONE when k=2; gen_done bits for other requesters SHALL be ignored.
REQ-019 all_spawned SHALL be 1 only in SEQ_DONE.
REQ-020 level_start in any sequencer state SHALL clear the occupancy table and move the sequencer to SEQ_GEN0 on the next cycle.
REQ-021 The check FSM SHALL use states CHK_IDLE, CHK_LOOKUP and CHK_EVAL, and it SHALL operate independently of the sequencer state.
REQ-022 In CHK_IDLE with any chk_req bit set, the block SHALL grant the requester using round-robin priority, starting with the index after the last grant.
REQ-023 After reset, requester 0 SHALL have the highest priority.
REQ-024 On a grant, the block SHALL latch the grant index, chk_x and chk_y, drive maze_rd_x and maze_rd_y from the latch, and enter CHK_LOOKUP.
REQ-025 The block SHALL then enter CHK_EVAL, sample maze_is_wall, and pulse chk_ack[g] with chk_valid[g] in that cycle.
REQ-026 The check FSM SHALL return to CHK_IDLE after CHK_EVAL, giving a latency of exactly 2 cycles from grant to ack and at most one check in flight.
REQ-027 A check SHALL be valid only if the tile is in range, maze_is_wall=0, the tile is not the pacman tile, and the tile is not in the occupancy table.
REQ-028 The occupancy table SHALL hold 8 entries of (x,y) with per-entry valid bits.
REQ-029 A valid result SHALL write the tile into the lowest free entry in the CHK_EVAL cycle.
REQ-030 When the table is full, a valid result SHALL still be returned but not recorded, and the sticky occ_overflow flag SHALL be set until level_start.
REQ-031 A lookup of the table SHALL see entries written by any earlier completed check, back-to-back included.
REQ-032 level_start while the check FSM is in CHK_LOOKUP or CHK_EVAL SHALL abort the check: no chk_ack, no table write, and a return to CHK_IDLE; the requester, still holding chk_req, is re-arbitrated.
REQ-033 busy SHALL equal (check FSM != CHK_IDLE) OR (sequencer in SEQ_GEN0..SEQ_GEN2).
REQ-034 Coordinates SHALL be compared as unsigned 7-bit values, with no wrap-around.

Reset
REQ-035 While resetN=0, the block SHALL force the sequencer to SEQ_IDLE, the check FSM to CHK_IDLE, and the round-robin pointer to favour requester 0.
REQ-036 While resetN=0, the block SHALL clear the occupancy table.
REQ-037 While resetN=0, should_generate, chk_ack, chk_valid, all_spawned, busy and occ_overflow SHALL be 0, and maze_rd_x and maze_rd_y SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL discard any in-flight check with no ack.

Configuration
REQ-039 With macro SPAWN_PM_EXCLUSION_EN defined, the pacman rule in REQ-027 SHALL reject any tile within Chebyshev distance 1 of (pm_tile_x, pm_tile_y), i.e. a 3x3 block clipped at 0.
REQ-040 With SPAWN_PM_EXCLUSION_EN undefined, the block SHALL reject only the exact pacman tile.

Verification
REQ-041 After reset, pulse level_start, then raise gen_done[0], gen_done[1] and gen_done[2] in turn; should_generate SHALL go 001 -> 010 -> 100 -> 000, and all_spawned SHALL be 1 after gen_done[2].
REQ-042 chk_req=001 at (5,3) with maze_is_wall=0 and pacman at (20,20) SHALL give chk_ack=001 two cycles after the grant with chk_valid[0]=1; the same tile requested again by requester 1 SHALL return valid=0.
REQ-043 chk_req=111 held continuously SHALL produce grant order 0,1,2,0 and an ack every 3 cycles.
REQ-044 Nine distinct valid tiles SHALL all return valid=1, and occ_overflow SHALL rise on the ninth; a subsequent level_start SHALL clear occ_overflow and the table.
REQ-045 Checks at (40,3) and at a wall tile SHALL both return valid=0; with the macro on and pacman at (10,10), a check at (11,9) SHALL return 0, and with the macro off it SHALL return 1.
REQ-046 level_start in the CHK_LOOKUP cycle SHALL produce no ack and a re-grant within 2 cycles, and resetN low mid-check SHALL drive all outputs to 0.
